// File: rtl/types_pkg.sv
// Shared core types: CDB broadcast record, register/ROB index widths and ROB age helper.
// Age is the wrap-around distance from the ROB head; a smaller age means an older instruction.
package types_pkg;

  localparam int ROB_IDX_W  = 5;
  localparam int PREG_W     = 7;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [PREG_W-1:0]     pd;
    logic [ROB_IDX_W-1:0]  rob;
    logic [CDB_DATA_W-1:0] data;
  } cdb_data_t;

  function automatic logic [ROB_IDX_W-1:0] rob_age(input logic [ROB_IDX_W-1:0] idx,
                                                   input logic [ROB_IDX_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/cdb_req_buf.sv
// Per-FU compacting result buffer; slot 0 is the oldest arrival, push visible at head after one edge.
// No internal backpressure: the caller only pushes while count < DEPTH; squash drops younger entries.
module cdb_req_buf
  import types_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [PREG_W-1:0]     push_pd,
  input  logic [ROB_IDX_W-1:0]  push_rob,
  input  logic [CDB_DATA_W-1:0] push_data,
  input  logic                  pop,
  input  logic [ROB_IDX_W-1:0]  rob_head,
  input  logic                  squash,
  input  logic [ROB_IDX_W-1:0]  squash_tag,
  output logic [CW-1:0]         count,
  output cdb_data_t             head
);

  localparam logic [CW-1:0] ONE = CW'(1);

  cdb_data_t            slot_q [DEPTH];
  cdb_data_t            slot_d [DEPTH];
  logic [DEPTH-1:0]     keep;
  logic [ROB_IDX_W-1:0] tag_age;
  logic                 push_ok;
  int                   pos [DEPTH];
  int                   n_keep;

  assign tag_age = rob_age(squash_tag, rob_head);
  assign push_ok = push && !(squash && (rob_age(push_rob, rob_head) > tag_age));

  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      keep[s] = slot_q[s].valid && !(pop && (s == 0))
                && !(squash && (rob_age(slot_q[s].rob, rob_head) > tag_age));
    end
  end

  // Survivors slide down in arrival order; a new push lands right behind them.
  always_comb begin
    n_keep = 0;
    for (int s = 0; s < DEPTH; s++) begin
      pos[s] = n_keep;
      if (keep[s]) n_keep = n_keep + 1;
    end
    for (int d = 0; d < DEPTH; d++) begin
      slot_d[d] = '0;
      for (int s = 0; s < DEPTH; s++) begin
        if (keep[s] && (pos[s] == d)) slot_d[d] = slot_q[s];
      end
      if (push_ok && (n_keep == d)) begin
        slot_d[d] = '{valid: 1'b1, pd: push_pd, rob: push_rob, data: push_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) slot_q[s] <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) slot_q[s] <= slot_d[s];
    end
  end

  always_comb begin
    count = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (slot_q[s].valid) count = count + ONE;
    end
  end

  assign head = slot_q[0];

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one buffered FU result per cycle onto a registered bus, push-to-CDB latency two edges.
// Backpressure via req_ready (buffer not full), CDB never stalls; CDB_AGE_PRIORITY_EN selects oldest-first over round-robin.
module cdb_arbiter
  import types_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0][PREG_W-1:0]      req_pd,
  input  logic [N_REQ-1:0][ROB_IDX_W-1:0]   req_rob,
  input  logic [N_REQ-1:0][DATA_W-1:0]      req_data,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [ROB_IDX_W-1:0]              rob_head,
  input  logic                              mispredict,
  input  logic [ROB_IDX_W-1:0]              mispredict_tag,
  output logic                              cdb_valid,
  output logic [PREG_W-1:0]                 cdb_pd,
  output logic [ROB_IDX_W-1:0]              cdb_rob,
  output logic [DATA_W-1:0]                 cdb_data
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  cdb_data_t            head  [N_REQ];
  logic [CW-1:0]        count [N_REQ];
  logic [N_REQ-1:0]     cand;
  logic [N_REQ-1:0]     grant;
  logic [ROB_IDX_W-1:0] tag_age;
  cdb_data_t            win;
  cdb_data_t            cdb_q;

  assign tag_age = rob_age(mispredict_tag, rob_head);

  for (genvar i = 0; i < N_REQ; i++) begin : g_buf
    cdb_req_buf #(.DEPTH(DEPTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (req_valid[i] & req_ready[i]),
      .push_pd    (req_pd[i]),
      .push_rob   (req_rob[i]),
      .push_data  (req_data[i]),
      .pop        (grant[i]),
      .rob_head   (rob_head),
      .squash     (mispredict),
      .squash_tag (mispredict_tag),
      .count      (count[i]),
      .head       (head[i])
    );
    assign req_ready[i] = count[i] < DEPTH_C;
    // A head younger than the mispredicted branch must not reach the bus this cycle.
    assign cand[i] = head[i].valid && !(mispredict && (rob_age(head[i].rob, rob_head) > tag_age));
  end

`ifdef CDB_AGE_PRIORITY_EN
  logic [ROB_IDX_W-1:0] best_age;

  always_comb begin
    grant    = '0;
    best_age = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i] && ((grant == '0) || (rob_age(head[i].rob, rob_head) < best_age))) begin
        grant    = '0;
        grant[i] = 1'b1;
        best_age = rob_age(head[i].rob, rob_head);
      end
    end
  end
`else
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_next;

  always_comb begin
    grant   = '0;
    rr_next = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((grant == '0) && cand[i] && (i == ((int'(rr_ptr) + k) % N_REQ))) begin
          grant[i] = 1'b1;
          rr_next  = PW'((i + 1) % N_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) rr_ptr <= '0;
    else        rr_ptr <= rr_next;
  end
`endif

  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win = head[i];
    end
  end

  // Idle cycles only drop valid; the payload fields keep the last broadcast.
  always_ff @(posedge clk) begin
    if (!reset)        cdb_q       <= '0;
    else if (|grant)   cdb_q       <= win;
    else               cdb_q.valid <= 1'b0;
  end

  assign cdb_valid = cdb_q.valid;
  assign cdb_pd    = cdb_q.pd;
  assign cdb_rob   = cdb_q.rob;
  assign cdb_data  = cdb_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle, plus directed literal scenarios.
// Build with +define+CDB_AGE_PRIORITY_EN to exercise oldest-first selection.
module tb_cdb_arbiter;

  localparam int N_REQ  = 3;
  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0][6:0]         req_pd;
  logic [N_REQ-1:0][4:0]         req_rob;
  logic [N_REQ-1:0][DATA_W-1:0]  req_data;
  logic [N_REQ-1:0]              req_ready;
  logic [4:0]                    rob_head;
  logic                          mispredict;
  logic [4:0]                    mispredict_tag;
  logic                          cdb_valid;
  logic [6:0]                    cdb_pd;
  logic [4:0]                    cdb_rob;
  logic [DATA_W-1:0]             cdb_data;

  cdb_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_pd         (req_pd),
    .req_rob        (req_rob),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rob_head       (rob_head),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .cdb_valid      (cdb_valid),
    .cdb_pd         (cdb_pd),
    .cdb_rob        (cdb_rob),
    .cdb_data       (cdb_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0]        pd;
    logic [4:0]        rob;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mq [N_REQ][$];
  int                m_rr = 0;
  bit                m_ok = 1'b0;
  logic              m_vld;
  logic [6:0]        m_pd;
  logic [4:0]        m_rob;
  logic [DATA_W-1:0] m_data;

  function automatic int age(input logic [4:0] r, input logic [4:0] h);
    return (int'(r) - int'(h) + 32) % 32;
  endfunction

  function automatic bit dies(input logic [4:0] r);
    return mispredict && (age(r, rob_head) > age(mispredict_tag, rob_head));
  endfunction

  always @(posedge clk) begin : model
    int   win;
    int   sel;
    bit   rdy [N_REQ];
    ent_t ent;
    ent_t keep [$];
    if (reset === 1'b0) begin
      for (int i = 0; i < N_REQ; i++) mq[i].delete();
      m_rr = 0; m_vld = 1'b0; m_pd = '0; m_rob = '0; m_data = '0; m_ok = 1'b1;
    end else if (m_ok) begin
      win = -1;
      for (int i = 0; i < N_REQ; i++) rdy[i] = mq[i].size() < DEPTH;
      for (int k = 0; k < N_REQ; k++) begin
`ifdef CDB_AGE_PRIORITY_EN
        sel = k;
        if (mq[sel].size() > 0 && !dies(mq[sel][0].rob))
          if (win < 0 || age(mq[sel][0].rob, rob_head) < age(mq[win][0].rob, rob_head)) win = sel;
`else
        sel = (m_rr + k) % N_REQ;
        if (win < 0 && mq[sel].size() > 0 && !dies(mq[sel][0].rob)) win = sel;
`endif
      end
      if (win >= 0) begin
        ent = mq[win].pop_front();
        m_vld = 1'b1; m_pd = ent.pd; m_rob = ent.rob; m_data = ent.data;
        m_rr = (win + 1) % N_REQ;
      end else begin
        m_vld = 1'b0;
      end
      if (mispredict) begin
        for (int i = 0; i < N_REQ; i++) begin
          keep.delete();
          for (int j = 0; j < mq[i].size(); j++)
            if (!dies(mq[i][j].rob)) keep.push_back(mq[i][j]);
          mq[i] = keep;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && rdy[i] && !dies(req_rob[i])) begin
          ent.pd = req_pd[i]; ent.rob = req_rob[i]; ent.data = req_data[i];
          mq[i].push_back(ent);
        end
      end
    end
  end

  // ---------------- per-cycle compare + broadcast log ----------------
  logic [4:0] bq [$];

  task automatic compare_loop();
    logic [N_REQ-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        for (int i = 0; i < N_REQ; i++) exp_rdy[i] = mq[i].size() < DEPTH;
        chk("cmp_cdb_valid", cdb_valid, m_vld);
        chk("cmp_cdb_pd",    cdb_pd,    m_pd);
        chk("cmp_cdb_rob",   cdb_rob,   m_rob);
        chk("cmp_cdb_data",  cdb_data,  m_data);
        chk("cmp_req_ready", req_ready, exp_rdy);
      end
      if (cdb_valid === 1'b1) bq.push_back(cdb_rob);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  function automatic bit taken(input logic [4:0] r, input int upto);
    for (int i = 0; i < N_REQ; i++)
      for (int j = 0; j < mq[i].size(); j++)
        if (mq[i][j].rob == r) return 1'b1;
    for (int i = 0; i < upto; i++)
      if (req_rob[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [4:0]       e1, e2, e3, f1, f2;
    logic [4:0]       r;
    logic [N_REQ-1:0] acc;
    logic [N_REQ-1:0] low_seen;
    int               n_acc;
    int               start;
    int               distinct;
    bit               seen [32];
    bit               found6, found7;
    logic [4:0]       seq;

    reset = 1'b0; req_valid = '0; req_pd = '0; req_rob = '0; req_data = '0;
    rob_head = '0; mispredict = 1'b0; mispredict_tag = '0;
    fork
      compare_loop();
    join_none

    // Reset held for 4 cycles
    repeat (4) tick();
    chk("reset_cdb_valid", cdb_valid, 1'b0);
    chk("reset_cdb_pd",    cdb_pd,    7'd0);
    chk("reset_req_ready", req_ready, 3'b111);
    reset = 1'b1;

    // Single ALU result
    req_valid = 3'b001; req_pd[0] = 7'd20; req_rob[0] = 5'd3; req_data[0] = 32'hDEADBEEF;
    tick();
    req_valid = '0;
    chk("single_not_yet", cdb_valid, 1'b0);
    tick();
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_pd",    cdb_pd,    7'd20);
    chk("single_rob",   cdb_rob,   5'd3);
    chk("single_data",  cdb_data,  32'hDEADBEEF);
    tick();
    chk("single_one_cycle", cdb_valid, 1'b0);
    chk("single_pd_hold",   cdb_pd,    7'd20);

    // Three-way tie from a fresh rr pointer
    do_reset();
    req_valid = 3'b111;
    req_pd[0] = 7'd10; req_rob[0] = 5'd5; req_data[0] = 32'h100;
    req_pd[1] = 7'd11; req_rob[1] = 5'd2; req_data[1] = 32'h101;
    req_pd[2] = 7'd12; req_rob[2] = 5'd9; req_data[2] = 32'h102;
    tick();
    req_valid = '0;
`ifdef CDB_AGE_PRIORITY_EN
    e1 = 5'd2; e2 = 5'd5; e3 = 5'd9;
`else
    e1 = 5'd5; e2 = 5'd2; e3 = 5'd9;
`endif
    tick(); chk("tie_first_valid", cdb_valid, 1'b1); chk("tie_first_rob", cdb_rob, e1);
    tick(); chk("tie_second_valid", cdb_valid, 1'b1); chk("tie_second_rob", cdb_rob, e2);
    tick(); chk("tie_third_valid", cdb_valid, 1'b1); chk("tie_third_rob", cdb_rob, e3);

    // Backpressure: all FUs offer every cycle for 12 cycles
    do_reset();
    tick();
    seq = 5'd0; n_acc = 0; low_seen = '0; start = bq.size();
    for (int i = 0; i < N_REQ; i++) begin
      req_rob[i] = seq; req_pd[i] = 7'($urandom); req_data[i] = $urandom; seq = seq + 5'd1;
    end
    req_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      acc = req_valid & req_ready;
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i]) begin
          n_acc++;
          req_rob[i] = seq; req_pd[i] = 7'($urandom); req_data[i] = $urandom; seq = seq + 5'd1;
        end
      end
      low_seen = low_seen | ~req_ready;
    end
    req_valid = '0;
    repeat (10) tick();
    for (int k = 0; k < 32; k++) seen[k] = 1'b0;
    distinct = 0;
    for (int k = start; k < bq.size(); k++)
      if (!seen[bq[k]]) begin seen[bq[k]] = 1'b1; distinct++; end
    chk("bp_total_bcast",  bq.size() - start, n_acc);
    chk("bp_distinct",     distinct, n_acc);
    chk("bp_ready_dropped", low_seen, 3'b111);

    // Mispredict squash of buffered and same-cycle younger results
    do_reset();
    rob_head = 5'd0;
    start = bq.size();
    req_valid = 3'b011;
    req_pd[0] = 7'd30; req_rob[0] = 5'd3; req_data[0] = 32'h3;
    req_pd[1] = 7'd31; req_rob[1] = 5'd7; req_data[1] = 32'h7;
    tick();
    req_valid = 3'b100; req_pd[2] = 7'd32; req_rob[2] = 5'd6; req_data[2] = 32'h6;
    mispredict = 1'b1; mispredict_tag = 5'd4;
    tick();
    req_valid = '0; mispredict = 1'b0;
    chk("sq_branch_valid", cdb_valid, 1'b1);
    chk("sq_branch_rob",   cdb_rob,   5'd3);
    repeat (4) tick();
    found6 = 1'b0; found7 = 1'b0;
    for (int k = start; k < bq.size(); k++) begin
      if (bq[k] == 5'd6) found6 = 1'b1;
      if (bq[k] == 5'd7) found7 = 1'b1;
    end
    chk("sq_rob7_absent", found7, 1'b0);
    chk("sq_rob6_absent", found6, 1'b0);
    chk("sq_empty_ready", req_ready, 3'b111);
    chk("sq_idle",        cdb_valid, 1'b0);

    // ROB index wrap around the head
    do_reset();
    rob_head = 5'd30;
    req_valid = 3'b011;
    req_rob[0] = 5'd1;  req_pd[0] = 7'd40; req_data[0] = 32'h1;
    req_rob[1] = 5'd31; req_pd[1] = 7'd41; req_data[1] = 32'h31;
    tick();
    req_valid = '0;
`ifdef CDB_AGE_PRIORITY_EN
    f1 = 5'd31; f2 = 5'd1;
`else
    f1 = 5'd1; f2 = 5'd31;
`endif
    tick(); chk("wrap_first_rob", cdb_rob, f1);
    tick(); chk("wrap_second_rob", cdb_rob, f2);

    // Randomised traffic with unique in-flight ROB indices
    for (int c = 0; c < 400; c++) begin
      reset = !(c >= 200 && c < 202);
      rob_head = 5'($urandom);
      mispredict = ($urandom_range(0, 7) == 0);
      mispredict_tag = 5'($urandom);
      for (int i = 0; i < N_REQ; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_pd[i] = 7'($urandom);
        req_data[i] = $urandom;
        r = 5'($urandom);
        for (int t = 0; t < 32; t++) begin
          if (taken(r, i)) r = r + 5'd1;
        end
        req_rob[i] = r;
      end
      tick();
    end
    req_valid = '0; mispredict = 1'b0;
    repeat (8) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
